// File: rtl/memory_request_arbiter_pkg.sv
// Shared types and constants for the memory request arbiter and its ID FIFO.
// Address and data widths match the memory read queue interface.
package memory_request_arbiter_pkg;

    localparam int MEM_ADDR_W          = 32;
    localparam int MEM_DATA_W          = 32;
    localparam int DEFAULT_NUM_EU      = 4;
    localparam int MEM_MAX_OUTSTANDING = 8;

    typedef logic [MEM_ADDR_W-1:0]              MemoryAddress;
    typedef logic [MEM_DATA_W-1:0]              MemoryWord;
    typedef logic [$clog2(DEFAULT_NUM_EU)-1:0]  EuIndex;

endpackage

// File: rtl/memory_request_arbiter_request_id_fifo.sv
// In-order FIFO of requester IDs for reads issued to memory and not yet returned.
// Push is ignored when full, pop is ignored when empty.
module request_id_fifo
    import memory_request_arbiter_pkg::*;
#(
    parameter int WIDTH = $bits(EuIndex),
    parameter int DEPTH = MEM_MAX_OUTSTANDING
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        // NOTE: every variable gets a default before any condition, so no latch can be inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end

    // NOTE: storage is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/memory_request_arbiter.sv
// Round-robin arbiter sharing the memory read queue among NUM_EU requesters and
// routing in-order read responses back to the requester that issued each read.
module memory_request_arbiter
    import memory_request_arbiter_pkg::*;
#(
    parameter int NUM_EU          = DEFAULT_NUM_EU,
    parameter int MAX_OUTSTANDING = MEM_MAX_OUTSTANDING
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_EU-1:0]                    eu_req,
    input  MemoryAddress [NUM_EU-1:0]            eu_addr,
    output logic [NUM_EU-1:0]                    eu_grant,
    output logic [NUM_EU-1:0]                    eu_resp_valid,
    output MemoryWord                            eu_resp_data,
    output logic                                 mem_req_valid,
    output MemoryAddress                         mem_req_addr,
    input  logic                                 mem_queue_full,
    input  logic                                 mem_resp_valid,
    input  MemoryWord                            mem_resp_data,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_count,
    output logic                                 resp_error
);

    localparam int IDX_W = $clog2(NUM_EU);

    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NUM_EU-1:0] eu_grant_q, eu_grant_d;
    logic [NUM_EU-1:0] eu_resp_valid_q, eu_resp_valid_d;
    MemoryWord         eu_resp_data_q, eu_resp_data_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    MemoryAddress      mem_req_addr_q, mem_req_addr_d;
    logic              resp_error_q, resp_error_d;

    logic [NUM_EU-1:0] eligible;
    logic [IDX_W-1:0]  winner;
    logic              found;
    logic              issue;
    logic              resp_pop;
    logic [IDX_W-1:0]  fifo_head;
    logic              fifo_full, fifo_empty;
    int                scan_idx;

    // A requester whose grant is visible this cycle is still holding its request; mask it.
    assign eligible = eu_req & ~eu_grant_q;

    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_EU; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NUM_EU;
            if (!found && eligible[scan_idx]) begin
                found  = 1'b1;
                winner = IDX_W'(scan_idx);
            end
        end
    end

    // fifo_full reflects the registered count, so a same-cycle pop never frees a slot early.
    assign issue    = found && !mem_queue_full && !fifo_full;
    assign resp_pop = mem_resp_valid && !fifo_empty;

    request_id_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (issue),
        .data_i  (winner),
        .pop_i   (resp_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_count)
    );

    always_comb begin
        eu_grant_d      = '0;
        eu_resp_valid_d = '0;
        mem_req_valid_d = issue;
        mem_req_addr_d  = mem_req_addr_q;
        eu_resp_data_d  = eu_resp_data_q;
        rr_ptr_d        = rr_ptr_q;
        resp_error_d    = resp_error_q || (mem_resp_valid && fifo_empty);
        if (issue) begin
            eu_grant_d[winner] = 1'b1;
            mem_req_addr_d     = eu_addr[winner];
            rr_ptr_d           = (winner == IDX_W'(NUM_EU-1)) ? '0 : winner + IDX_W'(1);
        end
        if (resp_pop) begin
            eu_resp_valid_d[fifo_head] = 1'b1;
            eu_resp_data_d             = mem_resp_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q        <= '0;
            eu_grant_q      <= '0;
            eu_resp_valid_q <= '0;
            eu_resp_data_q  <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            resp_error_q    <= 1'b0;
        end else begin
            rr_ptr_q        <= rr_ptr_d;
            eu_grant_q      <= eu_grant_d;
            eu_resp_valid_q <= eu_resp_valid_d;
            eu_resp_data_q  <= eu_resp_data_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            resp_error_q    <= resp_error_d;
        end
    end

    assign eu_grant      = eu_grant_q;
    assign eu_resp_valid = eu_resp_valid_q;
    assign eu_resp_data  = eu_resp_data_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign resp_error    = resp_error_q;

endmodule

// File: tb/tb_memory_request_arbiter.sv
// Randomized bench: a queue-based reference model predicts every output cycle and a
// monitor compares the DUT against those predictions one cycle later.
module tb_memory_request_arbiter;
    import memory_request_arbiter_pkg::*;

    localparam int N = 4;
    localparam int M = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N-1:0]         eu_req = '0;
    MemoryAddress [N-1:0] eu_addr = '0;
    logic [N-1:0]         eu_grant;
    logic [N-1:0]         eu_resp_valid;
    MemoryWord            eu_resp_data;
    logic                 mem_req_valid;
    MemoryAddress         mem_req_addr;
    logic                 mem_queue_full = 1'b0;
    logic                 mem_resp_valid = 1'b0;
    MemoryWord            mem_resp_data = '0;
    logic [3:0]           outstanding_count;
    logic                 resp_error;

    memory_request_arbiter #(.NUM_EU(N), .MAX_OUTSTANDING(M)) dut (
        .clk               (clk),
        .rst               (rst),
        .eu_req            (eu_req),
        .eu_addr           (eu_addr),
        .eu_grant          (eu_grant),
        .eu_resp_valid     (eu_resp_valid),
        .eu_resp_data      (eu_resp_data),
        .mem_req_valid     (mem_req_valid),
        .mem_req_addr      (mem_req_addr),
        .mem_queue_full    (mem_queue_full),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_data     (mem_resp_data),
        .outstanding_count (outstanding_count),
        .resp_error        (resp_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] grant;
        logic [N-1:0] rvalid;
        logic [31:0]  rdata;
        logic         mvalid;
        logic [31:0]  maddr;
        int           cnt;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   rr;
    int   id_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one step of the arbiter given the inputs currently driven.
    task automatic model_step();
        exp_t nx;
        int   size, w, idx, h;
        nx        = cur;
        nx.grant  = '0;
        nx.rvalid = '0;
        nx.mvalid = 1'b0;
        if (!rst) begin
            nx.rdata = '0;
            nx.maddr = '0;
            nx.cnt   = 0;
            nx.err   = 1'b0;
            rr       = 0;
            id_q.delete();
        end else begin
            size = id_q.size();
            if (mem_resp_valid) begin
                if (size > 0) begin
                    h            = id_q.pop_front();
                    nx.rvalid[h] = 1'b1;
                    nx.rdata     = mem_resp_data;
                end else begin
                    nx.err = 1'b1;
                end
            end
            w = -1;
            for (int k = 0; k < N; k++) begin
                idx = (rr + k) % N;
                if (w < 0 && eu_req[idx] && !cur.grant[idx]) w = idx;
            end
            if (w >= 0 && !mem_queue_full && size < M) begin
                nx.grant[w] = 1'b1;
                nx.mvalid   = 1'b1;
                nx.maddr    = eu_addr[w];
                id_q.push_back(w);
                rr = (w + 1) % N;
            end
            nx.cnt = id_q.size();
        end
        cur = nx;
        exp_q.push_back(nx);
    endtask

    task automatic gen_inputs(int p_req, int p_full, int p_resp, bit allow_empty);
        for (int i = 0; i < N; i++) begin
            if (cur.grant[i] || !eu_req[i]) begin
                eu_req[i] = ($urandom_range(99) < p_req);
                if (eu_req[i]) eu_addr[i] = $urandom;
            end
        end
        mem_queue_full = ($urandom_range(99) < p_full);
        if (id_q.size() > 0 || allow_empty) mem_resp_valid = ($urandom_range(99) < p_resp);
        else                                mem_resp_valid = 1'b0;
        mem_resp_data = $urandom;
    endtask

    task automatic run(int cycles, int p_req, int p_full, int p_resp, bit allow_empty);
        repeat (cycles) begin
            @(negedge clk);
            rst = 1'b1;
            gen_inputs(p_req, p_full, p_resp, allow_empty);
            model_step();
        end
    endtask

    task automatic do_reset(int cycles);
        @(negedge clk);
        rst            = 1'b0;
        eu_req         = '0;
        mem_queue_full = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        model_step();
        #1;
        check("rst_grant",  64'(eu_grant), 64'd0);
        check("rst_rvalid", 64'(eu_resp_valid), 64'd0);
        check("rst_rdata",  64'(eu_resp_data), 64'd0);
        check("rst_mvalid", 64'(mem_req_valid), 64'd0);
        check("rst_maddr",  64'(mem_req_addr), 64'd0);
        check("rst_count",  64'(outstanding_count), 64'd0);
        check("rst_error",  64'(resp_error), 64'd0);
        repeat (cycles - 1) begin
            @(negedge clk);
            model_step();
        end
    endtask

    // Monitor: compares each registered output set against the oldest prediction.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("eu_grant",          64'(eu_grant), 64'(e.grant));
            check("mem_req_valid",     64'(mem_req_valid), 64'(e.mvalid));
            check("mem_req_addr",      64'(mem_req_addr), 64'(e.maddr));
            check("eu_resp_valid",     64'(eu_resp_valid), 64'(e.rvalid));
            check("eu_resp_data",      64'(eu_resp_data), 64'(e.rdata));
            check("outstanding_count", 64'(outstanding_count), 64'(e.cnt));
            check("resp_error",        64'(resp_error), 64'(e.err));
        end
    end

    initial begin
        cur = '{grant: '0, rvalid: '0, rdata: '0, mvalid: 1'b0, maddr: '0, cnt: 0, err: 1'b0};
        rr  = 0;
        do_reset(3);
        run(200, 60, 20, 50, 1'b0);  // mixed traffic
        run(5, 100, 100, 0, 1'b0);   // memory queue backpressure
        run(30, 100, 0, 0, 1'b0);    // fill all outstanding slots, then stall
        run(60, 50, 10, 60, 1'b0);   // release with responses
        run(20, 0, 0, 100, 1'b0);    // drain
        run(5, 0, 0, 100, 1'b1);     // responses with nothing outstanding
        run(3, 100, 0, 0, 1'b0);     // three reads in flight
        do_reset(2);
        run(200, 70, 25, 50, 1'b0);
        run(15, 0, 0, 100, 1'b0);
        @(posedge clk);
        #2;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
